areset_sync_sequencer: RTL and testbench



---
 rtl/areset_sync_sequencer_if.sv | 30 +++
 rtl/areset_sync_sequencer.sv | 150 +++++++++++++++
 tb/tb_areset_sync_sequencer.sv | 116 +++++++++++
 3 files changed

// File: rtl/areset_sync_sequencer_if.sv
/*------------------------------------------------------------------------------
 * areset_sync_sequencer_if : software-request and per-domain reset bundle
 * Revision 1.0
 *----------------------------------------------------------------------------*/
`default_nettype none

interface areset_sync_sequencer_if #(
  parameter int NUM_DOMAINS = 3
);
  logic                   sw_reset_req;
  logic [NUM_DOMAINS-1:0] reset_out;
  logic                   reset_done;
  logic                   reset_cause;

  modport master (
    output sw_reset_req,
    input  reset_out,
    input  reset_done,
    input  reset_cause
  );

  modport slave (
    input  sw_reset_req,
    output reset_out,
    output reset_done,
    output reset_cause
  );
endinterface

`default_nettype wire

// File: rtl/areset_sync_sequencer.sv
/*------------------------------------------------------------------------------
 * areset_sync_sequencer : async-assert / sync-release staggered reset generator
 * Revision 1.0
 *----------------------------------------------------------------------------*/
`default_nettype none

module areset_sync_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int STRETCH_CYCLES = 16,
  parameter int NUM_DOMAINS    = 3,
  parameter int STAGE_GAP      = 4
) (
  input  logic                    clk,
  input  logic                    async_reset,
  areset_sync_sequencer_if.slave  bus
);

  localparam int CNT_MAX = (STRETCH_CYCLES > STAGE_GAP) ? STRETCH_CYCLES : STAGE_GAP;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [1:0] S_SYNC    = 2'd0;
  localparam logic [1:0] S_STRETCH = 2'd1;
  localparam logic [1:0] S_SEQ     = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_ok;
  logic [1:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] out_q, out_d;
  logic                   done_q, done_d;
  logic                   cause_q, cause_d;

  logic w_stretch_end;
  logic w_gap_end;
  logic w_last_idx;

  assign sync_ok       = sync_q[SYNC_STAGES-1];
  assign w_stretch_end = (cnt_q == CNT_W'(STRETCH_CYCLES - 1));
  assign w_gap_end     = (cnt_q == CNT_W'(STAGE_GAP - 1));
  assign w_last_idx    = (idx_q == IDX_W'(NUM_DOMAINS - 1));

  // Every flop clears on the async edge; release only ever happens on clk.
  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset) begin
      sync_q  <= '0;
      state_q <= S_SYNC;
      cnt_q   <= '0;
      idx_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
      cause_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], 1'b1};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      done_q  <= done_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    case (state_q)
      S_SYNC: begin
        if (sync_ok) begin
          state_d = S_STRETCH;
          cnt_d   = '0;
        end
      end
      S_STRETCH: begin
        if (w_stretch_end) begin
          state_d = (NUM_DOMAINS == 1) ? S_DONE : S_SEQ;
          idx_d   = IDX_W'(1);
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SEQ: begin
        if (w_gap_end) begin
          cnt_d = '0;
          idx_d = idx_q + IDX_W'(1);
          if (w_last_idx) begin
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        if (bus.sw_reset_req) begin
          state_d = S_STRETCH;
          cnt_d   = '0;
        end
      end
    endcase
  end

  // Next values of the registered outputs; nothing here reaches a port unflopped.
  always_comb begin
    out_d   = out_q;
    done_d  = done_q;
    cause_d = cause_q;
    case (state_q)
      S_STRETCH: begin
        if (w_stretch_end) begin
          out_d[0] = 1'b1;
          if (NUM_DOMAINS == 1) begin
            done_d = 1'b1;
          end
        end
      end
      S_SEQ: begin
        if (w_gap_end) begin
          for (int i = 1; i < NUM_DOMAINS; i++) begin
            if (idx_q == IDX_W'(i)) begin
              out_d[i] = 1'b1;
            end
          end
          if (w_last_idx) begin
            done_d = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (bus.sw_reset_req) begin
          out_d   = '0;
          done_d  = 1'b0;
          cause_d = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  assign bus.reset_out   = out_q;
  assign bus.reset_done  = done_q;
  assign bus.reset_cause = cause_q;

endmodule

`default_nettype wire

// File: tb/tb_areset_sync_sequencer.sv
/*------------------------------------------------------------------------------
 * tb_areset_sync_sequencer : directed bench for default and corner configs
 * Revision 1.0
 *----------------------------------------------------------------------------*/
`default_nettype none

module tb_areset_sync_sequencer;

  logic clk;
  logic async_reset;

  areset_sync_sequencer_if #(.NUM_DOMAINS(3)) bus   ();
  areset_sync_sequencer_if #(.NUM_DOMAINS(1)) bus_c ();

  areset_sync_sequencer #(
    .SYNC_STAGES(2), .STRETCH_CYCLES(16), .NUM_DOMAINS(3), .STAGE_GAP(4)
  ) dut (
    .clk(clk), .async_reset(async_reset), .bus(bus)
  );

  areset_sync_sequencer #(
    .SYNC_STAGES(3), .STRETCH_CYCLES(1), .NUM_DOMAINS(1), .STAGE_GAP(1)
  ) dut_c (
    .clk(clk), .async_reset(async_reset), .bus(bus_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int ec    = 0;
  int base  = 19;
  bit cause_e = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, ec, obs, exp);
    end
  endtask

  // Expected outputs from the current release base (edge of reset_out[0]).
  task automatic check_all();
    logic [2:0] oe;
    for (int i = 0; i < 3; i++) oe[i] = (ec >= base + 4 * i);
    chk("out",     {29'd0, bus.reset_out}, {29'd0, oe});
    chk("done",    {31'd0, bus.reset_done}, {31'd0, (ec >= base + 8)});
    chk("cause",   {31'd0, bus.reset_cause}, {31'd0, cause_e});
    chk("c_out",   {31'd0, bus_c.reset_out}, {31'd0, (ec >= 5)});
    chk("c_done",  {31'd0, bus_c.reset_done}, {31'd0, (ec >= 5)});
    chk("c_cause", {31'd0, bus_c.reset_cause}, 32'd0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_out"},   {29'd0, bus.reset_out}, 32'd0);
    chk({tag, "_done"},  {31'd0, bus.reset_done}, 32'd0);
    chk({tag, "_cause"}, {31'd0, bus.reset_cause}, 32'd0);
    chk({tag, "_cout"},  {31'd0, bus_c.reset_out}, 32'd0);
  endtask

  // Advance to edge `last`, checking after every rising edge.
  task automatic run(input int last, input bit sw_sched);
    while (ec < last) begin
      @(posedge clk);
      ec++;
      #1;
      if (sw_sched && (ec == 28 || ec == 56)) begin
        base    = ec + 16;
        cause_e = 1'b1;
      end
      check_all();
      if (sw_sched) bus.sw_reset_req = ((ec >= 4 && ec < 30) || ec == 55);
    end
  endtask

  initial begin
    async_reset        = 1'b0;
    bus.sw_reset_req   = 1'b0;
    bus_c.sw_reset_req = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_zero("por");

    // Power-on release, request held across the whole sequence, then a pulse in DONE.
    @(negedge clk);
    async_reset = 1'b1;
    ec = 0; base = 19; cause_e = 1'b0;
    run(82, 1'b1);

    // Sub-cycle glitch must clear everything without a clock edge.
    #2 async_reset = 1'b0;
    #1 check_zero("glitch");
    #2 async_reset = 1'b1;
    ec = 0; base = 19; cause_e = 1'b0;
    run(24, 1'b0);

    // Abort in SEQ between edges, hold across an edge, then full restart.
    #2 async_reset = 1'b0;
    #1 check_zero("abort");
    @(posedge clk);
    #1 check_zero("abort_hold");
    @(negedge clk);
    async_reset = 1'b1;
    ec = 0; base = 19; cause_e = 1'b0;
    run(28, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
